processor_param: RTL and testbench

PROCESSOR_PARAM -- requirements
Module: processor_param

---
 rtl/processor_param.sv | 154 +++++++++++++++
 tb/tb_processor_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_param.sv
// ---------------------------------------------------------------------------
// processor_param -- tiny multi-cycle processor with eight general registers.
//
// Each instruction is fetched from DataIn in T0 when Run is high and then
// executed over one (mv, mvi, undefined opcodes) or three (ALU ops) further
// cycles. All register traffic goes through a single internal bus, which is
// exported on BusWires.
//
// Instruction word (DataIn[8:0]): opcode [8:6], Rx [5:3], Ry [2:0].
//   000 mv  Rx <- Ry        001 mvi Rx <- DataIn (operand in T1)
//   010 add Rx <- Rx + Ry   011 sub Rx <- Rx - Ry
//   100 and Rx <- Rx & Ry   (only when PROC_LOGIC_EN is defined)
//   others: no-op that finishes in T1
//
// Build option: define PROC_LOGIC_EN to include the AND instruction.
//
// Ports:
//   clock    in   single clock, rising edge
//   Reset    in   synchronous, active-high; clears state, IR, A, G, R0..R7
//   Run      in   start request, sampled only in T0
//   DataIn   in   W  instruction word (T0) / immediate operand (T1 of mvi)
//   Done     out  high during the final cycle of each instruction
//   BusWires out  W  internal bus value
//
// Parameters: W (bus/register width, >= 9), NREG (fixed at 8).
// ---------------------------------------------------------------------------
module processor_param #(
    parameter int W    = 9,
    parameter int NREG = 8
) (
    input  logic         clock,
    input  logic         Reset,
    input  logic         Run,
    input  logic [W-1:0] DataIn,
    output logic         Done,
    output logic [W-1:0] BusWires
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;

    logic [1:0]   tstep;
    logic [8:0]   ir;
    logic [W-1:0] regs [NREG];
    logic [W-1:0] a;
    logic [W-1:0] g;
    logic [W-1:0] alu_result;

    logic [2:0]   opcode;
    logic [2:0]   rx;
    logic [2:0]   ry;
    logic         is_alu;

    assign opcode = ir[8:6];
    assign rx     = ir[5:3];
    assign ry     = ir[2:0];

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
`ifdef PROC_LOGIC_EN
        if (opcode == OP_AND) is_alu = 1'b1;
`endif
    end

    // The ALU is only used in T2, when A holds the old Rx and the bus carries
    // Ry; both were sampled before any write, so Rx == Ry works naturally.
    always_comb begin
        alu_result = '0;
        case (opcode)
            OP_ADD: alu_result = a + BusWires;
            OP_SUB: alu_result = a - BusWires;
`ifdef PROC_LOGIC_EN
            OP_AND: alu_result = a & BusWires;
`endif
            default: alu_result = '0;
        endcase
    end

    // Bus source and Done decode.
    always_comb begin
        Done     = 1'b0;
        BusWires = '0;
        case (tstep)
            T1: begin
                if (is_alu) begin
                    BusWires = regs[rx];
                end else begin
                    Done = 1'b1;
                    if (opcode == OP_MV)       BusWires = regs[ry];
                    else if (opcode == OP_MVI) BusWires = DataIn;
                end
            end
            T2: BusWires = regs[ry];
            T3: begin
                BusWires = g;
                Done     = 1'b1;
            end
            default: BusWires = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    always_ff @(posedge clock) begin
        if (Reset) begin
            tstep <= T0;
            ir    <= '0;
            a     <= '0;
            g     <= '0;
            // NOTE: the register file is reset explicitly because software
            // may read any register straight after reset and must see 0.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (tstep)
                T0: begin
                    if (Run) begin
                        ir    <= DataIn[8:0];
                        tstep <= T1;
                    end
                end
                T1: begin
                    if (is_alu) begin
                        a     <= BusWires;
                        tstep <= T2;
                    end else begin
                        if (opcode == OP_MV || opcode == OP_MVI)
                            regs[rx] <= BusWires;
                        tstep <= T0;
                    end
                end
                T2: begin
                    g     <= alu_result;
                    tstep <= T3;
                end
                T3: begin
                    regs[rx] <= g;
                    tstep    <= T0;
                end
                default: tstep <= T0;
            endcase
        end
    end

endmodule

// File: tb/tb_processor_param.sv
module tb_processor_param;

    localparam int W = 9;

    logic         clock;
    logic         Reset;
    logic         Run;
    logic [W-1:0] DataIn;
    logic         Done;
    logic [W-1:0] BusWires;

    // Second instance for the wide-bus case.
    logic         Run16;
    logic [15:0]  DataIn16;
    logic         Done16;
    logic [15:0]  BusWires16;

    processor_param #(.W(W)) dut (
        .clock(clock), .Reset(Reset), .Run(Run), .DataIn(DataIn),
        .Done(Done), .BusWires(BusWires)
    );

    processor_param #(.W(16)) dut16 (
        .clock(clock), .Reset(Reset), .Run(Run16), .DataIn(DataIn16),
        .Done(Done16), .BusWires(BusWires16)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_errors = 0;

`ifdef PROC_LOGIC_EN
    localparam bit LOGIC_EN = 1'b1;
`else
    localparam bit LOGIC_EN = 1'b0;
`endif

    // Reference model: architectural register file plus the expected bus
    // value for every cycle after T0, derived from the instruction semantics.
    logic [W-1:0] mreg [8];
    logic [W-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_step(input logic [8:0] instr, input logic [W-1:0] imm);
        int op = int'(instr[8:6]);
        int rx = int'(instr[5:3]);
        int ry = int'(instr[2:0]);
        logic [W-1:0] res;
        exp_q.delete();
        if (op == 0) begin
            exp_q.push_back(mreg[ry]);
            mreg[rx] = mreg[ry];
        end else if (op == 1) begin
            exp_q.push_back(imm);
            mreg[rx] = imm;
        end else if (op == 2 || op == 3 || (op == 4 && LOGIC_EN)) begin
            if (op == 2)      res = W'((longint'(mreg[rx]) + longint'(mreg[ry])) % (longint'(1) << W));
            else if (op == 3) res = W'((longint'(mreg[rx]) - longint'(mreg[ry]) + (longint'(1) << W)) % (longint'(1) << W));
            else              res = mreg[rx] & mreg[ry];
            exp_q.push_back(mreg[rx]);
            exp_q.push_back(mreg[ry]);
            exp_q.push_back(res);
            mreg[rx] = res;
        end else begin
            exp_q.push_back('0);
        end
    endfunction

    // Runs one instruction from T0 to its Done cycle, comparing the bus in
    // each cycle and the latency against the model.
    task automatic exec(input logic [8:0] instr, input logic [W-1:0] imm,
                        output int lat, output logic [W-1:0] last);
        model_step(instr, imm);
        @(negedge clock);
        Run    = 1'b1;
        DataIn = '0;
        DataIn[8:0] = instr;
        #1 check("t0_done", Done, 0);
        @(posedge clock);
        @(negedge clock);
        Run    = 1'b0;
        DataIn = imm;
        lat  = 0;
        last = '0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            last = BusWires;
            if (c <= exp_q.size()) check("bus", BusWires, exp_q[c-1]);
            if (Done) begin
                lat = c + 1;
                break;
            end
            if (c == 4) break;
            @(posedge clock);
            @(negedge clock);
        end
        check("latency", lat, exp_q.size() + 1);
    endtask

    task automatic read_all_regs();
        int lat;
        logic [W-1:0] last;
        for (int k = 0; k < 8; k++) begin
            exec({3'b000, 3'(k), 3'(k)}, '0, lat, last);
            check("reg_read", last, mreg[k]);
        end
    endtask

    typedef struct {
        logic [8:0]   instr;
        logic [W-1:0] imm;
        int           lat;
        logic [W-1:0] bus_final;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int lat;
        logic [W-1:0] last;

        vecs[0]  = '{9'b001_000_000, 9'd5,     2, 9'd5};     // mvi R0,#5
        vecs[1]  = '{9'b000_001_000, 9'd0,     2, 9'd5};     // mv R1,R0
        vecs[2]  = '{9'b010_000_001, 9'd0,     4, 9'd10};    // add R0,R1
        vecs[3]  = '{9'b001_010_000, 9'd0,     2, 9'd0};     // mvi R2,#0
        vecs[4]  = '{9'b011_010_000, 9'd0,     4, 9'h1F6};   // sub R2,R0
        vecs[5]  = '{9'b001_011_000, 9'h0F0,   2, 9'h0F0};   // mvi R3,#F0
        vecs[6]  = '{9'b001_100_000, 9'h03C,   2, 9'h03C};   // mvi R4,#3C
        if (LOGIC_EN) begin
            vecs[7] = '{9'b100_011_100, 9'd0,  4, 9'h030};   // and R3,R4
            vecs[8] = '{9'b000_011_011, 9'd0,  2, 9'h030};   // read R3
        end else begin
            vecs[7] = '{9'b100_011_100, 9'd0,  2, 9'h000};   // undefined
            vecs[8] = '{9'b000_011_011, 9'd0,  2, 9'h0F0};   // read R3
        end
        vecs[9]  = '{9'b111_001_010, 9'h1FF,   2, 9'h000};   // undefined 111
        vecs[10] = '{9'b010_000_000, 9'd0,     4, 9'd20};    // add R0,R0
        vecs[11] = '{9'b000_010_010, 9'd0,     2, 9'h1F6};   // read R2

        Reset    = 1'b1;
        Run      = 1'b0;
        DataIn   = '0;
        Run16    = 1'b0;
        DataIn16 = '0;
        for (int k = 0; k < 8; k++) mreg[k] = '0;
        @(posedge clock);
        @(negedge clock);
        Reset = 1'b0;
        #1;
        check("reset_done", Done, 0);
        check("reset_bus", BusWires, 0);

        // Idle with Run low: stays in T0.
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            check("idle_done", Done, 0);
            check("idle_bus", BusWires, 0);
        end

        // Wide instance: mvi R0,#FFFF with junk in the ignored upper bits.
        @(negedge clock);
        Run16    = 1'b1;
        DataIn16 = 16'hFE40;
        @(posedge clock);
        @(negedge clock);
        Run16    = 1'b0;
        DataIn16 = 16'hFFFF;
        #1;
        check("w16_mvi_done", Done16, 1);
        check("w16_mvi_bus", BusWires16, 16'hFFFF);
        @(negedge clock);
        Run16    = 1'b1;
        DataIn16 = 16'h0000;             // mv R0,R0
        @(posedge clock);
        @(negedge clock);
        Run16 = 1'b0;
        #1;
        check("w16_r0", BusWires16, 16'hFFFF);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            exec(vecs[i].instr, vecs[i].imm, lat, last);
            check("vec_latency", lat, vecs[i].lat);
            check("vec_bus", last, vecs[i].bus_final);
        end
        read_all_regs();

        // Run held high through Done starts the next instruction at once.
        @(negedge clock);
        Run    = 1'b1;
        DataIn = 9'b000_001_001;
        @(posedge clock);
        @(negedge clock);
        #1;
        check("hold_t1_done", Done, 1);
        check("hold_t1_bus", BusWires, mreg[1]);
        @(negedge clock);
        #1;
        check("hold_t0_done", Done, 0);
        check("hold_t0_bus", BusWires, 0);
        @(negedge clock);
        #1;
        check("hold_t1b_done", Done, 1);
        Run = 1'b0;

        // Randomized instructions against the model.
        for (int i = 0; i < 60; i++) begin
            exec(9'($urandom_range(0, 511)), W'($urandom), lat, last);
        end
        read_all_regs();

        // Make R0/R1 nonzero, then reset during T2 of add R0,R1.
        exec(9'b001_000_000, 9'd7, lat, last);
        exec(9'b001_001_000, 9'd3, lat, last);
        @(negedge clock);
        Run    = 1'b1;
        DataIn = 9'b010_000_001;
        @(posedge clock);
        @(negedge clock);
        Run = 1'b0;
        @(negedge clock);
        #1;
        check("t2_bus", BusWires, 9'd3);
        check("t2_done", Done, 0);
        Reset = 1'b1;
        @(negedge clock);
        Reset = 1'b0;
        #1;
        check("abort_done", Done, 0);
        check("abort_bus", BusWires, 0);
        for (int k = 0; k < 8; k++) mreg[k] = '0;
        read_all_regs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
